// File: rtl/clk_meter_pkg.sv
// Shared types and default widths for the clock edge meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int WIN_W_DEF       = 8;
  localparam int CNT_W_DEF       = 5;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_rise_det.sv
// Synchronizes an asynchronous clock-like input and emits a one-cycle pulse per rising edge.
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/clk_edge_meter.sv
// Counts rising edges of sig_in over a programmable window of clk cycles.
// Optional saturation flag output enabled by CLK_EDGE_METER_OVF_EN.
module clk_edge_meter
  import clk_meter_pkg::*;
#(
  parameter int WIN_W       = WIN_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
`ifdef CLK_EDGE_METER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != CNT_MAX)) return c + CNT_ONE;
    return c;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_result;
  logic             r_result_valid;
  logic             w_rise;
  logic             w_start_ok;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_nxt;

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_sig  (sig_in),
    .o_rise (w_rise)
  );

  assign w_start_ok = start && (win_len != '0);
  assign w_last     = (r_state == MEASURE) && (r_win_cnt == WIN_ONE);
  assign w_cnt_nxt  = sat_inc(r_edge_cnt, w_rise);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = MEASURE;
      MEASURE: if (w_last) w_state_nxt = HOLD;
      HOLD:    if (r_result_valid && result_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The final window cycle's rise is folded into the latched result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt      <= '0;
      r_edge_cnt     <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_win_cnt  <= win_len;
            r_edge_cnt <= '0;
          end
        end
        MEASURE: begin
          r_win_cnt  <= r_win_cnt - WIN_ONE;
          r_edge_cnt <= w_cnt_nxt;
          if (w_last) begin
            r_result       <= w_cnt_nxt;
            r_result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) r_result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CLK_EDGE_METER_OVF_EN
  logic r_ovf_acc;
  logic r_overflow;
  logic w_drop;

  assign w_drop = w_rise && (r_edge_cnt == CNT_MAX);

  // Accumulates any increment lost to saturation across the whole window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_acc  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_start_ok) r_ovf_acc <= 1'b0;
        MEASURE: begin
          r_ovf_acc <= r_ovf_acc | w_drop;
          if (w_last) r_overflow <= r_ovf_acc | w_drop;
        end
        HOLD:    if (r_result_valid && result_ready) r_overflow <= 1'b0;
        default: ;
      endcase
    end
  end

  assign overflow = r_overflow;
`endif

  assign busy         = (r_state != IDLE);
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule
